// File: rtl/key_sweep_pkg.sv
// key_sweep_pkg: shared types and defaults for the c499 key-sweep controller.
// Holds the FSM state encoding, default widths and key bit positions.
package key_sweep_pkg;

    localparam int KEY_W_DEF = 6;
    localparam int IN_W_DEF  = 41;
    localparam int OUT_W_DEF = 32;
    localparam int NVEC_DEF  = 16;
    localparam int VA_W_DEF  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_FETCH,
        S_LOAD,
        S_CHECK,
        S_DONE
    } state_e;

    // Bit position of each key input inside dut_key.
    // Index order is {p1,p2,p3,p4,X_1,X_2}, MSB first.
    typedef enum int {
        KB_X2 = 0,
        KB_X1 = 1,
        KB_P4 = 2,
        KB_P3 = 3,
        KB_P2 = 4,
        KB_P1 = 5
    } key_bit_e;

endpackage

// File: rtl/sweep_result_acc.sv
// sweep_result_acc: survivor bitmap, population count and first-hit key.
// Cleared at sweep start, updated once per fully matching candidate.
module sweep_result_acc #(
    parameter int KEY_W = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    acc_i,
    input  logic [KEY_W-1:0]        idx_i,
    output logic [(1<<KEY_W)-1:0]   surv_o,
    output logic [KEY_W:0]          cnt_o,
    output logic                    found_o,
    output logic [KEY_W-1:0]        first_o
);

    localparam logic [KEY_W:0] CNT_ONE = 1;

    logic [(1<<KEY_W)-1:0] surv_q;
    logic [KEY_W:0]        cnt_q;
    logic                  found_q;
    logic [KEY_W-1:0]      first_q;

    // Record a surviving candidate; the first one seen is the lowest index.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            surv_q  <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            first_q <= '0;
        end else if (acc_i) begin
            surv_q[idx_i] <= 1'b1;
            cnt_q         <= cnt_q + CNT_ONE;
            if (!found_q) begin
                found_q <= 1'b1;
                first_q <= idx_i;
            end
        end
    end

    assign surv_o  = surv_q;
    assign cnt_o   = cnt_q;
    assign found_o = found_q;
    assign first_o = first_q;

endmodule

// File: rtl/key_sweep_ctrl.sv
// key_sweep_ctrl: exhaustive key-candidate sweep over a locked c499 netlist.
// Applies stored vectors per legal key and keeps candidates that never miss.
module key_sweep_ctrl
    import key_sweep_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int NVEC  = NVEC_DEF,
    parameter int VA_W  = VA_W_DEF
) (
    input  logic                    CK,
    input  logic                    RST,
    input  logic                    start,
    input  logic                    abort,
    input  logic [(1<<KEY_W)-1:0]   key_allow,
    output logic [VA_W-1:0]         vec_addr,
    input  logic [IN_W-1:0]         vec_data,
    input  logic [OUT_W-1:0]        orc_data,
    output logic [IN_W-1:0]         dut_in,
    output logic [KEY_W-1:0]        dut_key,
    input  logic [OUT_W-1:0]        dut_out,
    output logic                    busy,
    output logic                    done,
    output logic [(1<<KEY_W)-1:0]   surv,
    output logic [KEY_W:0]          surv_cnt,
    output logic                    found,
    output logic [KEY_W-1:0]        first_key
);

    if (NVEC < 1) begin : g_nvec_chk
        $error("key_sweep_ctrl: NVEC must be >= 1");
    end

    state_e                 state_q;
    logic [KEY_W-1:0]       k_q;
    logic [VA_W-1:0]        v_q;
    logic [(1<<KEY_W)-1:0]  allow_q;
    logic [IN_W-1:0]        din_q;
    logic [OUT_W-1:0]       exp_q;
    logic [KEY_W-1:0]       key_q;

    logic k_last;
    logic v_last;
    logic idle_st;
    logic busy_st;
    logic go;
    logic stop;
    logic match;
    logic acc;

    assign k_last  = (k_q == '1);
    assign v_last  = (v_q == VA_W'(NVEC - 1));
    assign idle_st = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy_st = !idle_st;
    assign go      = start && !abort && idle_st;
    assign stop    = abort && busy_st;
    assign match   = (dut_out == exp_q);
    assign acc     = (state_q == S_CHECK) && !abort && match && v_last;

    // Sweep sequencer: key select, vector fetch/load, compare.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            v_q     <= '0;
            allow_q <= '0;
            din_q   <= '0;
            exp_q   <= '0;
            key_q   <= '0;
        end else if (stop) begin
            state_q <= S_DONE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        allow_q <= key_allow;
                        k_q     <= '0;
                        v_q     <= '0;
                        state_q <= S_KEY;
                    end
                end
                S_KEY: begin
                    if (allow_q[k_q]) begin
                        key_q   <= k_q;
                        v_q     <= '0;
                        state_q <= S_FETCH;
                    end else if (k_last) begin
                        state_q <= S_DONE;
                    end else begin
                        k_q <= k_q + KEY_W'(1);
                    end
                end
                S_FETCH: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    din_q   <= vec_data;
                    exp_q   <= orc_data;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (match && !v_last) begin
                        v_q     <= v_q + VA_W'(1);
                        state_q <= S_FETCH;
                    end else if (k_last) begin
                        state_q <= S_DONE;
                    end else begin
                        k_q     <= k_q + KEY_W'(1);
                        state_q <= S_KEY;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    sweep_result_acc #(
        .KEY_W (KEY_W)
    ) u_acc (
        .clk_i   (CK),
        .rst_i   (RST),
        .clr_i   (go),
        .acc_i   (acc),
        .idx_i   (k_q),
        .surv_o  (surv),
        .cnt_o   (surv_cnt),
        .found_o (found),
        .first_o (first_key)
    );

    assign vec_addr = v_q;
    assign dut_in   = din_q;
    assign dut_key  = key_q;
    assign busy     = busy_st;
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_key_sweep_ctrl.sv
// tb_key_sweep_ctrl: directed bench for key_sweep_ctrl.
// ROM, oracle and locked-netlist models are behavioural.
module tb_key_sweep_ctrl;

    logic        CK;
    logic        RST;
    logic        start;
    logic        abort;
    logic [63:0] key_allow;
    logic [3:0]  vec_addr;
    logic [40:0] vec_data;
    logic [31:0] orc_data;
    logic [40:0] dut_in;
    logic [5:0]  dut_key;
    logic [31:0] dut_out;
    logic        busy;
    logic        done;
    logic [63:0] surv;
    logic [6:0]  surv_cnt;
    logic        found;
    logic [5:0]  first_key;

    logic [63:0] good;
    int          n_chk;
    int          n_err;
    int          cyc;
    logic [3:0]  va_seen;

    key_sweep_ctrl dut (
        .CK        (CK),
        .RST       (RST),
        .start     (start),
        .abort     (abort),
        .key_allow (key_allow),
        .vec_addr  (vec_addr),
        .vec_data  (vec_data),
        .orc_data  (orc_data),
        .dut_in    (dut_in),
        .dut_key   (dut_key),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .surv      (surv),
        .surv_cnt  (surv_cnt),
        .found     (found),
        .first_key (first_key)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    function automatic logic [40:0] mk_vec(input logic [3:0] a);
        return {33'(a) * 33'd13 + 33'd1, 4'h0, a};
    endfunction

    function automatic logic [31:0] golden(input logic [40:0] x);
        return x[31:0] ^ {x[40:32], 23'h0} ^ 32'hA5A5_0F0F;
    endfunction

    // Registered ROM: data valid the cycle after the address.
    always @(posedge CK) begin
        vec_data <= mk_vec(vec_addr);
        orc_data <= golden(mk_vec(vec_addr));
    end

    // Locked netlist: wrong key k corrupts bit 0 on vector k%16.
    assign dut_out = golden(dut_in)
        ^ {31'h0, !good[dut_key] && (dut_in[3:0] == dut_key[3:0])};

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic kick();
        @(negedge CK);
        start = 1'b1;
        @(posedge CK);
        cyc = 1;
        @(negedge CK);
        start = 1'b0;
    endtask

    task automatic step();
        @(posedge CK);
        cyc++;
        @(negedge CK);
        va_seen = va_seen | vec_addr;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_done();
        while (!done && cyc < 5000) step();
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, 64'(vec_addr), 64'd0);
        chk({tag, "_din"}, 64'(dut_in), 64'd0);
        chk({tag, "_key"}, 64'(dut_key), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_surv"}, surv, 64'd0);
        chk({tag, "_cnt"}, 64'(surv_cnt), 64'd0);
        chk({tag, "_found"}, 64'(found), 64'd0);
        chk({tag, "_first"}, 64'(first_key), 64'd0);
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        cyc       = 0;
        va_seen   = '0;
        RST       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        key_allow = '0;
        good      = '0;
        repeat (3) @(posedge CK);
        @(negedge CK);
        chk_zero("rst");
        RST = 1'b0;

        // All-zero mask: 64 KEY cycles, no vector traffic.
        key_allow = '0;
        kick();
        va_seen = vec_addr;
        wait_done();
        chk("zero_cyc", 64'(cyc), 64'd65);
        chk("zero_found", 64'(found), 64'd0);
        chk("zero_surv", surv, 64'd0);
        chk("zero_addr", 64'(va_seen), 64'd0);

        // Single legal key, which is the correct one.
        key_allow = 64'd1 << 5;
        good      = 64'd1 << 5;
        kick();
        chk("k5_busy", 64'(busy), 64'd1);
        wait_done();
        chk("k5_cyc", 64'(cyc), 64'd113);
        chk("k5_surv", surv, 64'd1 << 5);
        chk("k5_cnt", 64'(surv_cnt), 64'd1);
        chk("k5_first", 64'(first_key), 64'd5);
        chk("k5_found", 64'(found), 64'd1);
        chk("k5_busy_end", 64'(busy), 64'd0);

        // Back-to-back restart from DONE with a new mask.
        key_allow = 64'd1 << 9;
        good      = (64'd1 << 5) | (64'd1 << 9);
        kick();
        chk("b2b_surv_clr", surv, 64'd0);
        chk("b2b_cnt_clr", 64'(surv_cnt), 64'd0);
        chk("b2b_found_clr", 64'(found), 64'd0);
        chk("b2b_first_clr", 64'(first_key), 64'd0);
        chk("b2b_done_clr", 64'(done), 64'd0);
        wait_done();
        chk("b2b_cyc", 64'(cyc), 64'd113);
        chk("b2b_surv", surv, 64'd1 << 9);
        chk("b2b_first", 64'(first_key), 64'd9);

        // Full sweep, two correct keys; wrong keys fail at k%16.
        key_allow = '1;
        good      = (64'd1 << 5) | (64'd1 << 9);
        kick();
        wait_done();
        chk("all_cyc", 64'(cyc), 64'd1745);
        chk("all_surv", surv, (64'd1 << 5) | (64'd1 << 9));
        chk("all_cnt", 64'(surv_cnt), 64'd2);
        chk("all_first", 64'(first_key), 64'd5);

        // Abort during CHECK of key 9 (cycle 61).
        key_allow = (64'd1 << 5) | (64'd1 << 9);
        kick();
        run_to(61);
        chk("ab_key", 64'(dut_key), 64'd9);
        chk("ab_surv_pre", surv, 64'd1 << 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_done", 64'(done), 64'd1);
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_surv", surv, 64'd1 << 5);
        chk("ab_cnt", 64'(surv_cnt), 64'd1);
        chk("ab_first", 64'(first_key), 64'd5);
        chk("ab_found", 64'(found), 64'd1);

        // Reset in LOAD of key 5 (cycle 8).
        key_allow = 64'd1 << 5;
        kick();
        run_to(8);
        chk("rl_key", 64'(dut_key), 64'd5);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_zero("rl");

        // start while busy must not disturb the sweep.
        key_allow = (64'd1 << 5) | (64'd1 << 9);
        kick();
        run_to(30);
        start = 1'b1;
        step();
        start = 1'b0;
        run_to(80);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done();
        chk("sb_cyc", 64'(cyc), 64'd161);
        chk("sb_surv", surv, (64'd1 << 5) | (64'd1 << 9));
        chk("sb_cnt", 64'(surv_cnt), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/key_sweep_ctrl.md
Name: key_sweep_ctrl

Overview:
Sequences a key-locked c499 SEC netlist (41 data/check inputs, 32 outputs, 6 key bits: p1..p4 and X_1,X_2) through an exhaustive key-candidate sweep.
- For each allowed key it applies a stored test-vector set and compares the netlist outputs against stored oracle responses.
- It aborts a candidate on its first mismatch and records the keys that survive.
- It sits between the vector/oracle ROM and the locked netlist instance in the deobfuscation harness.

Parameters:
KEY_W, 6, key width; key space is 2**KEY_W candidates, indexed 0..2**KEY_W-1; key bit order {p1,p2,p3,p4,X_1,X_2}, MSB first.
IN_W, 41, netlist primary-input width.
OUT_W, 32, netlist primary-output width.
NVEC, 16, number of test vectors; must be >= 1 (elaboration assertion).
VA_W, 4, vector address width; ceil(log2(NVEC)), minimum 1.

Ports:
CK  in  1  clock; the only clock.
RST  in  1  reset; synchronous, active-high.
start  in  1  begin a sweep; honoured only in IDLE or DONE.
abort  in  1  synchronous stop; FSM goes to DONE next cycle.
key_allow  in  2**KEY_W  bit k=1 means candidate k is legal; sampled at start.
vec_addr  out  VA_W  ROM address.
vec_data  in  IN_W  ROM vector; valid the cycle after vec_addr is presented.
orc_data  in  OUT_W  oracle response, same timing as vec_data.
dut_in  out  IN_W  registered drive to the netlist inputs.
dut_key  out  KEY_W  registered key drive (current candidate).
dut_out  in  OUT_W  netlist outputs (combinational from dut_in/dut_key).
busy  out  1  high in every state except IDLE and DONE.
done  out  1  high in DONE; held until the next start or RST.
surv  out  2**KEY_W  survivor bitmap.
surv_cnt  out  KEY_W+1  population count of surv.
found  out  1  surv_cnt != 0.
first_key  out  KEY_W  lowest surviving key index; 0 when found=0.

Behaviour:
Reset state: all outputs 0, FSM in IDLE. RST overrides everything, including an in-progress sweep.

Start:
- On start in IDLE or DONE: latch key_allow; clear surv, surv_cnt, found, first_key and done; set key index k=0; go to KEY.
- start in any other state is ignored.

FSM (one cycle per state visit):
- KEY: if allow[k]=0 and k is the last index -> DONE. If allow[k]=0 otherwise -> k++ and stay in KEY. If allow[k]=1 -> dut_key<=k, v<=0, go to FETCH.
- FETCH: drive vec_addr=v -> LOAD.
- LOAD: dut_in<=vec_data, exp<=orc_data -> CHECK.
- CHECK: compare dut_out with exp.
  - On mismatch: reject k (early abort).
  - On match with v<NVEC-1: v++ -> FETCH.
  - On match with v=NVEC-1: set surv[k], increment surv_cnt; if found was 0, first_key<=k and found<=1.
  - After a reject or a full match: k last -> DONE, else k++ -> KEY.
- DONE: hold all results; busy=0.

Timing and other rules:
- vec_addr holds its value outside FETCH; it is only required to be valid in FETCH.
- Per allowed key: 3 cycles per vector applied. A full pass costs 3*NVEC cycles; a mismatch at vector v costs 3*(v+1) cycles.
- Per disallowed key: 1 cycle.
- Abort has priority over all transitions except RST. Results gathered so far remain visible. The candidate in flight is not marked as a survivor.
- k wrap-around never occurs: the last index always exits to DONE.
- All-zero key_allow: 2**KEY_W cycles in KEY, then DONE with found=0.
- Comparison is full OUT_W-bit equality; there are no don't-care bits.

Decomposition:
- Shared package key_sweep_pkg holds: the state enum (IDLE, KEY, FETCH, LOAD, CHECK, DONE), KEY_W/IN_W/OUT_W defaults, and the key bit-position constants for p1..p4 and X_1,X_2.
- One sub-module, sweep_result_acc, holds surv/surv_cnt/first_key/found and is driven by accept/index/clear strobes.

Test Plan:
1. key_allow has only bit 5 set, oracle equals the netlist under key 5, NVEC=16, start -> done after 64+48+1 cycles; surv=1<<5, surv_cnt=1, first_key=5, found=1.
2. key_allow=all ones, keys 5 and 9 correct -> surv bits 5 and 9 only, surv_cnt=2, first_key=5. Each wrong key spends 3*(v+1) cycles, with v its first failing vector.
3. key_allow=0, start -> done after exactly 65 cycles; found=0, surv=0, vec_addr never leaves 0.
4. abort asserted during CHECK of key 9 with key 5 already a survivor -> next cycle DONE, busy=0, surv=1<<5, bit 9 clear.
5. RST asserted mid-LOAD -> next cycle all outputs 0 and FSM in IDLE. start issued while busy has no effect on k or surv.
6. Back-to-back sweep: start in DONE with a new key_allow -> results cleared the next cycle and the sweep reruns with the new mask.
